// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, port identifiers and the read-return tag for the RAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W           = 5;
    localparam int DATA_W           = 8;
    localparam int READ_LATENCY_DEF = 1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's view of the shared RAM: request/write payload in, grant and read return out.
interface ram_port_arbiter_if;

    logic                            req;
    logic                            we;
    logic [ram_arb_pkg::ADDR_W-1:0]  addr;
    logic [ram_arb_pkg::DATA_W-1:0]  wdata;
    logic                            gnt;
    logic                            rvalid;
    logic [ram_arb_pkg::DATA_W-1:0]  rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic       clk_50M,
    input  logic       RST_N,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grants are suppressed while reset is asserted so nothing is accepted and then dropped.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (RST_N) begin
            if (req == 2'b11) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
        if (gnt[PORT_A]) begin
            ptr_d = PORT_B;
        end else if (gnt[PORT_B]) begin
            ptr_d = PORT_A;
        end
    end

    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B: registered issue, tagged read return.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic              clk_50M,
    input  logic              RST_N,
    ram_port_arbiter_if.slave port_a,
    ram_port_arbiter_if.slave port_b,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int STAGES = READ_LATENCY + 1;

    logic [1:0] req;
    logic [1:0] gnt;

    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              rden_q, rden_d;

    rd_tag_t                tag_in;
    rd_tag_t [STAGES-1:0]   tag_q, tag_d;
    rd_tag_t                tag_mature;

    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    assign req = {port_b.req, port_a.req};

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk_50M (clk_50M),
        .RST_N   (RST_N),
        .req     (req),
        .gnt     (gnt)
    );

    assign port_a.gnt = gnt[PORT_A];
    assign port_b.gnt = gnt[PORT_B];

    // Idle cycles keep address/data so the RAM inputs only toggle on a real access.
    always_comb begin
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        tag_in    = '0;
        if (gnt[PORT_A]) begin
            address_d    = port_a.addr;
            data_d       = port_a.wdata;
            wren_d       = port_a.we;
            rden_d       = ~port_a.we;
            tag_in.valid = ~port_a.we;
            tag_in.port  = PORT_A;
        end else if (gnt[PORT_B]) begin
            address_d    = port_b.addr;
            data_d       = port_b.wdata;
            wren_d       = port_b.we;
            rden_d       = ~port_b.we;
            tag_in.valid = ~port_b.we;
            tag_in.port  = PORT_B;
        end
    end

    // The tag travels alongside the RAM read so q is claimed by the port that issued it.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = tag_in;
        for (int i = 1; i < STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_mature = tag_q[STAGES-1];

    always_comb begin
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        if (tag_mature.valid) begin
            if (tag_mature.port == PORT_A) begin
                rdata_a_d  = ram_q;
                rvalid_a_d = 1'b1;
            end else begin
                rdata_b_d  = ram_q;
                rvalid_b_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) begin
            address_q  <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            tag_q      <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            address_q  <= address_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            tag_q      <= tag_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign ram_address   = address_q;
    assign ram_data      = data_q;
    assign ram_wren      = wren_q;
    assign ram_rden      = rden_q;
    assign port_a.rvalid = rvalid_a_q;
    assign port_a.rdata  = rdata_a_q;
    assign port_b.rvalid = rvalid_b_q;
    assign port_b.rdata  = rdata_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x8 RAM (registered inputs, unregistered q).
module tb_ram_port_arbiter;

    logic       clk_50M = 1'b0;
    logic       RST_N   = 1'b0;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic       ram_rden;
    logic [7:0] ram_q;

    ram_port_arbiter_if if_a ();
    ram_port_arbiter_if if_b ();

    ram_port_arbiter dut (
        .clk_50M     (clk_50M),
        .RST_N       (RST_N),
        .port_a      (if_a),
        .port_b      (if_b),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    always #10 clk_50M = ~clk_50M;

    logic [7:0] mem [32];
    always @(posedge clk_50M) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_address];
    end

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // Monitor runs after the stimulus has settled in each low phase.
    int         rva_cnt = 0;
    int         rvb_cnt = 0;
    int         both_gnt = 0;
    int         both_en = 0;
    logic [7:0] rvb_data[$];
    int         rvb_cyc[$];
    always begin
        @(negedge clk_50M);
        #2;
        if (if_a.rvalid) rva_cnt++;
        if (if_b.rvalid) begin
            rvb_cnt++;
            rvb_data.push_back(if_b.rdata);
            rvb_cyc.push_back(cyc);
        end
        if (if_a.gnt && if_b.gnt) both_gnt++;
        if (ram_wren && ram_rden) both_en++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [4:0] ad, input logic [7:0] d);
        if_a.req = r; if_a.we = w; if_a.addr = ad; if_a.wdata = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [4:0] ad, input logic [7:0] d);
        if_b.req = r; if_b.we = w; if_b.addr = ad; if_b.wdata = d;
    endtask

    initial begin
        int na, nb, ncyc, base, bq;
        logic prev_a;

        // Reset with both requesting
        drive_a(1'b1, 1'b1, 5'd31, 8'hEE);
        drive_b(1'b1, 1'b1, 5'd30, 8'hDD);
        repeat (2) @(negedge clk_50M);
        #1;
        check_val("rst_gnt_a", 32'(if_a.gnt), 0);
        check_val("rst_gnt_b", 32'(if_b.gnt), 0);
        check_val("rst_addr", 32'(ram_address), 0);
        check_val("rst_data", 32'(ram_data), 0);
        check_val("rst_wren", 32'(ram_wren), 0);
        check_val("rst_rden", 32'(ram_rden), 0);
        check_val("rst_rvalid_a", 32'(if_a.rvalid), 0);
        check_val("rst_rvalid_b", 32'(if_b.rvalid), 0);
        check_val("rst_rdata_a", 32'(if_a.rdata), 0);
        check_val("rst_rdata_b", 32'(if_b.rdata), 0);
        RST_N = 1'b1;
        #1;
        check_val("rel_first_gnt_a", 32'(if_a.gnt), 1);
        check_val("rel_first_gnt_b", 32'(if_b.gnt), 0);
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        check_val("rel_second_gnt_b", 32'(if_b.gnt), 1);
        check_val("rel_issue_addr", 32'(ram_address), 31);
        check_val("rel_issue_data", 32'(ram_data), 32'hEE);
        check_val("rel_issue_wren", 32'(ram_wren), 1);
        @(negedge clk_50M);
        drive_b(1'b0, 1'b0, 5'd0, 8'h00);

        // Write 0x5A @3 then read it back
        @(negedge clk_50M);
        base = rva_cnt;
        drive_a(1'b1, 1'b1, 5'd3, 8'h5A);
        #1;
        check_val("wr_gnt_a", 32'(if_a.gnt), 1);
        @(negedge clk_50M);
        drive_a(1'b1, 1'b0, 5'd3, 8'h00);
        #1;
        check_val("wr_wren", 32'(ram_wren), 1);
        check_val("wr_rden", 32'(ram_rden), 0);
        check_val("wr_addr", 32'(ram_address), 3);
        check_val("wr_data", 32'(ram_data), 32'h5A);
        check_val("rd_gnt_a", 32'(if_a.gnt), 1);
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        check_val("rd_rden", 32'(ram_rden), 1);
        check_val("rd_wren", 32'(ram_wren), 0);
        check_val("rd_addr", 32'(ram_address), 3);
        @(negedge clk_50M);
        #1;
        check_val("rd_rvalid_early", 32'(if_a.rvalid), 0);
        @(negedge clk_50M);
        #1;
        check_val("rd_rvalid_n3", 32'(if_a.rvalid), 1);
        check_val("rd_rdata_n3", 32'(if_a.rdata), 32'h5A);
        @(negedge clk_50M);
        #3;
        check_val("rd_rvalid_pulse", 32'(if_a.rvalid), 0);
        check_val("rd_rdata_held", 32'(if_a.rdata), 32'h5A);
        check_val("rd_rvalid_count", 32'(rva_cnt - base), 1);

        // Both requesting: strict alternation, 8 grants each
        base = rvb_cnt;
        na = 0; nb = 0; ncyc = 0; prev_a = 1'b0;
        while (ncyc < 20 && (na < 8 || nb < 8)) begin
            @(negedge clk_50M);
            drive_a(na < 8, 1'b1, 5'(na + 8), 8'(na + 8'h80));
            drive_b(nb < 8, 1'b0, 5'(nb), 8'h00);
            #1;
            check_val("alt_one_gnt", 32'(int'(if_a.gnt) + int'(if_b.gnt)), 1);
            if (ncyc > 0) check_val("alt_order", 32'(if_a.gnt), 32'(!prev_a));
            prev_a = if_a.gnt;
            na += int'(if_a.gnt);
            nb += int'(if_b.gnt);
            ncyc++;
        end
        check_val("alt_cycles", 32'(ncyc), 16);
        check_val("alt_cnt_a", 32'(na), 8);
        check_val("alt_cnt_b", 32'(nb), 8);
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        drive_b(1'b0, 1'b0, 5'd0, 8'h00);
        repeat (4) @(negedge clk_50M);
        #3;
        check_val("alt_rvalid_b_count", 32'(rvb_cnt - base), 8);

        // A fills mem[i]=i, then B streams all 32 back
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_50M);
            drive_a(1'b1, 1'b1, 5'(i), 8'(i));
            #1;
            if (!if_a.gnt) check_val("fill_gnt_a", 32'(if_a.gnt), 1);
        end
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        bq = rvb_data.size();
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk_50M);
            drive_b(1'b1, 1'b0, 5'(i), 8'h00);
            #1;
            if (!if_b.gnt) check_val("stream_gnt_b", 32'(if_b.gnt), 1);
        end
        @(negedge clk_50M);
        drive_b(1'b0, 1'b0, 5'd0, 8'h00);
        repeat (5) @(negedge clk_50M);
        #3;
        check_val("stream_count", 32'(rvb_data.size() - bq), 32);
        if (rvb_data.size() - bq == 32) begin
            for (int i = 0; i < 32; i++) begin
                check_val("stream_data", 32'(rvb_data[bq + i]), 32'(i));
                if (i > 0) check_val("stream_spacing", 32'(rvb_cyc[bq + i] - rvb_cyc[bq + i - 1]), 1);
            end
        end

        // Reset one cycle after a read grant drops the read
        @(negedge clk_50M);
        base = rva_cnt;
        drive_a(1'b1, 1'b0, 5'd7, 8'h00);
        #1;
        check_val("abort_gnt_a", 32'(if_a.gnt), 1);
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        RST_N = 1'b0;
        #1;
        check_val("abort_rden_in_rst", 32'(ram_rden), 0);
        @(negedge clk_50M);
        #1;
        check_val("abort_rden_held", 32'(ram_rden), 0);
        RST_N = 1'b1;
        repeat (6) @(negedge clk_50M);
        #3;
        check_val("abort_no_rvalid", 32'(rva_cnt - base), 0);

        // B alone every cycle; pointer must come back to A
        @(negedge clk_50M);
        drive_a(1'b1, 1'b1, 5'd0, 8'h00);
        #1;
        check_val("solo_prime_gnt_a", 32'(if_a.gnt), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50M);
            drive_a(1'b0, 1'b0, 5'd0, 8'h00);
            drive_b(1'b1, 1'b1, 5'(i + 16), 8'h11);
            #1;
            check_val("solo_gnt_b", 32'(if_b.gnt), 1);
            check_val("solo_no_gnt_a", 32'(if_a.gnt), 0);
        end
        @(negedge clk_50M);
        drive_b(1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        check_val("idle_no_gnt", 32'(int'(if_a.gnt) + int'(if_b.gnt)), 0);
        @(negedge clk_50M);
        drive_a(1'b1, 1'b1, 5'd20, 8'h22);
        drive_b(1'b1, 1'b1, 5'd21, 8'h33);
        #1;
        check_val("tie_gnt_a", 32'(if_a.gnt), 1);
        check_val("tie_no_gnt_b", 32'(if_b.gnt), 0);
        @(negedge clk_50M);
        drive_a(1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        check_val("tie_then_gnt_b", 32'(if_b.gnt), 1);
        @(negedge clk_50M);
        drive_b(1'b0, 1'b0, 5'd0, 8'h00);
        repeat (2) @(negedge clk_50M);
        #3;

        check_val("never_both_gnt", 32'(both_gnt), 0);
        check_val("never_wren_rden", 32'(both_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
